// File: rtl/adc_align_pkg.sv
// -----------------------------------------------------------------------------
// adc_align_pkg
// Shared definitions for the ADC link-training controller:
//   - state_t       : training FSM states
//   - TRAIN_PAT_DEF : default training word (all 12 rotations distinct)
//   - NBITS_DEF / TAPW_DEF : default word width and IODELAY tap width
//   - rot_w()       : width of a rotation index for a given word width
//   - rotl()        : rotate-left of an n-bit word held in a MAXW container
// -----------------------------------------------------------------------------
package adc_align_pkg;

  localparam int NBITS_DEF = 12;
  localparam int TAPW_DEF  = 5;
  localparam int MAXW      = 64;

  localparam logic [NBITS_DEF-1:0] TRAIN_PAT_DEF = 12'hFC0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_SAMPLE,
    ST_EVAL,
    ST_CLOAD,
    ST_CSETTLE,
    ST_ROT,
    ST_NEXT_CH
  } state_t;

  // Rotation index width: $clog2(nbits), at least one bit.
  function automatic int rot_w(input int nbits);
    return (nbits <= 1) ? 1 : $clog2(nbits);
  endfunction

  // Rotate the low n bits of word left by r (r < n). Upper bits of the result
  // are zero. The word is duplicated so the rotation becomes a plain shift.
  function automatic logic [MAXW-1:0] rotl(input logic [MAXW-1:0] word,
                                           input int unsigned    r,
                                           input int unsigned    n = NBITS_DEF);
    logic [2*MAXW-1:0] mask;
    logic [2*MAXW-1:0] dbl;
    mask = ({{(2*MAXW-1){1'b0}}, 1'b1} << n) - {{(2*MAXW-1){1'b0}}, 1'b1};
    dbl  = {{MAXW{1'b0}}, word} & mask;
    dbl  = (dbl << n) | dbl;
    dbl  = dbl << r;
    dbl  = (dbl >> n) & mask;
    return dbl[MAXW-1:0];
  endfunction

endpackage

// File: rtl/adc_align_train_if.sv
// -----------------------------------------------------------------------------
// adc_align_train_if
// Bundle between the deserializer/IODELAY front end, the downstream DAQ logic
// and the training controller.
//   start   : one-cycle training request
//   din     : raw deserializer words, channel c at [c*NBITS +: NBITS]
//   dout    : rotation-corrected words (registered)
//   tap_val : per-channel IODELAY CNTVALUEIN, channel c at [c*TAPW +: TAPW]
//   tap_ld  : one-cycle per-channel load strobe
//   busy    : training in progress
//   done    : sticky, all channels processed
//   ch_ok   : sticky per-channel pass flags
// slave  = controller side, master = surrounding system side.
// -----------------------------------------------------------------------------
interface adc_align_train_if #(
  parameter int NCH   = 16,
  parameter int NBITS = 12,
  parameter int TAPW  = 5
);

  logic                  start;
  logic [NCH*NBITS-1:0]  din;
  logic [NCH*NBITS-1:0]  dout;
  logic [NCH*TAPW-1:0]   tap_val;
  logic [NCH-1:0]        tap_ld;
  logic                  busy;
  logic                  done;
  logic [NCH-1:0]        ch_ok;

  modport master (
    output start, din,
    input  dout, tap_val, tap_ld, busy, done, ch_ok
  );

  modport slave (
    input  start, din,
    output dout, tap_val, tap_ld, busy, done, ch_ok
  );

endinterface

// File: rtl/adc_align_train_eye.sv
// -----------------------------------------------------------------------------
// adc_eye_tracker
// Longest-run tracker for the delay-tap eye scan.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : forget all runs (start of a channel)
//   valid       : one tap result is presented this cycle
//   stable      : the tap presented was stable
//   tap         : tap index of the result
//   best_start  : first tap of the longest run so far
//   best_len    : length of the longest run so far (0 = none)
// The best run is updated while a run grows, so a run still open at the last
// tap needs no separate close step. A later run replaces the best only when it
// becomes strictly longer, so on equal length the first run wins.
// -----------------------------------------------------------------------------
module adc_eye_tracker #(
  parameter int TAPW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            valid,
  input  logic            stable,
  input  logic [TAPW-1:0] tap,
  output logic [TAPW-1:0] best_start,
  output logic [TAPW:0]   best_len
);

  logic [TAPW-1:0] cur_start;
  logic [TAPW:0]   cur_len;
  logic [TAPW-1:0] run_start;
  logic [TAPW:0]   run_len;

  assign run_start = (cur_len == '0) ? tap : cur_start;
  assign run_len   = cur_len + {{TAPW{1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (clear) begin
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else if (valid) begin
      if (stable) begin
        cur_start <= run_start;
        cur_len   <= run_len;
        if (run_len > best_len) begin
          best_start <= run_start;
          best_len   <= run_len;
        end
      end else begin
        cur_len <= '0;
      end
    end
  end

endmodule

// File: rtl/adc_align_train.sv
// -----------------------------------------------------------------------------
// adc_align_train
// ADC link-training controller. Channels are trained one after another: every
// delay tap is loaded, allowed to settle and sampled; the widest stable window
// is found and its centre tap loaded; then the word-boundary rotation that
// maps the settled word back to TRAIN_PAT is stored. All channels forward
// rotl(din, rot) through one register stage in every state.
//   frame_clk : frame-rate clock, rising edge
//   rst_n     : asynchronous active-low reset, aborts training
//   bus       : adc_align_train_if.slave (start/din in; dout, tap_val, tap_ld,
//               busy, done, ch_ok out)
// -----------------------------------------------------------------------------
module adc_align_train
  import adc_align_pkg::*;
#(
  parameter int               NCH         = 16,
  parameter int               NBITS       = NBITS_DEF,
  parameter int               TAPW        = TAPW_DEF,
  parameter logic [NBITS-1:0] TRAIN_PAT   = NBITS'(TRAIN_PAT_DEF),
  parameter int               SETTLE      = 8,
  parameter int               SAMPLES     = 16,
  parameter int               MIN_EYE     = 4,
  parameter int               DEFAULT_TAP = 25
) (
  input  logic              frame_clk,
  input  logic              rst_n,
  adc_align_train_if.slave  bus
);

  localparam int TAPS    = 2**TAPW;
  localparam int ROTW    = rot_w(NBITS);
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CNT_MAX = (SETTLE > SAMPLES) ? SETTLE : SAMPLES;
  localparam int CNTW    = $clog2(CNT_MAX + 1);

  localparam logic [TAPW-1:0] TAP_DEF    = TAPW'(DEFAULT_TAP);
  localparam logic [TAPW-1:0] TAP_LAST   = TAPW'(TAPS - 1);
  localparam logic [CHW-1:0]  CH_LAST    = CHW'(NCH - 1);
  localparam logic [CNTW-1:0] SETTLE_END = CNTW'(SETTLE - 1);
  localparam logic [CNTW-1:0] SAMPLE_END = CNTW'(SAMPLES - 1);
  localparam logic [TAPW:0]   MIN_EYE_L  = (TAPW+1)'(MIN_EYE);

  state_t state;
  state_t state_nx;

  logic [CHW-1:0]   ch;
  logic [TAPW-1:0]  tap;
  logic [CNTW-1:0]  cnt;
  logic [NBITS-1:0] first_w;
  logic             mism;
  logic             ch_fail;
  logic             done_r;
  logic [NCH-1:0]   ch_ok_r;
  logic [NCH-1:0]   tap_ld_r;

  logic [TAPW-1:0]  tap_r [NCH];
  logic [ROTW-1:0]  rot_r [NCH];
  logic [NBITS-1:0] din_w [NCH];

  logic [NBITS-1:0] din_ch;
  logic [NBITS-1:0] srch_word;
  logic             hit;
  logic [ROTW-1:0]  hit_r;

  logic             eye_clear;
  logic             eye_valid;
  logic             eye_stable;
  logic [TAPW-1:0]  best_start;
  logic [TAPW:0]    best_len;
  logic [TAPW-1:0]  centre;
  logic             eye_pass;

  assign din_ch = din_w[ch];

  // Rotation search: the first sampled word during the scan (is this tap
  // showing the pattern at all?), the live word once the centre is loaded.
  always_comb begin
    srch_word = (state == ST_ROT) ? din_ch : first_w;
    hit       = 1'b0;
    hit_r     = '0;
    for (int r = 0; r < NBITS; r++) begin
      if (NBITS'(rotl(MAXW'(srch_word), r, NBITS)) == TRAIN_PAT) begin
        hit   = 1'b1;
        hit_r = ROTW'(r);
      end
    end
  end

  assign eye_clear  = (state == ST_IDLE) || (state == ST_NEXT_CH);
  assign eye_valid  = (state == ST_EVAL);
  assign eye_stable = hit && !mism;

  adc_eye_tracker #(.TAPW(TAPW)) u_eye (
    .clk        (frame_clk),
    .rst_n      (rst_n),
    .clear      (eye_clear),
    .valid      (eye_valid),
    .stable     (eye_stable),
    .tap        (tap),
    .best_start (best_start),
    .best_len   (best_len)
  );

  assign centre   = best_start + best_len[TAPW:1];
  assign eye_pass = (best_len >= MIN_EYE_L);

  always_ff @(posedge frame_clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (bus.start) state_nx = ST_LOAD;
      ST_LOAD:    state_nx = ST_SETTLE;
      ST_SETTLE:  if (cnt == SETTLE_END) state_nx = ST_SAMPLE;
      ST_SAMPLE:  if (cnt == SAMPLE_END) state_nx = ST_EVAL;
      ST_EVAL:    state_nx = (tap == TAP_LAST) ? ST_CLOAD : ST_LOAD;
      ST_CLOAD:   state_nx = ST_CSETTLE;
      ST_CSETTLE: if (cnt == SETTLE_END) state_nx = ST_ROT;
      ST_ROT:     state_nx = ST_NEXT_CH;
      ST_NEXT_CH: state_nx = (ch == CH_LAST) ? ST_IDLE : ST_LOAD;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // Dwell counter restarts on every state change.
  always_ff @(posedge frame_clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (state_nx != state) cnt <= '0;
    else                        cnt <= cnt + {{(CNTW-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge frame_clk or negedge rst_n) begin
    if (!rst_n) begin
      ch       <= '0;
      tap      <= '0;
      first_w  <= '0;
      mism     <= 1'b0;
      ch_fail  <= 1'b0;
      done_r   <= 1'b0;
      ch_ok_r  <= '0;
      tap_ld_r <= '0;
      for (int c = 0; c < NCH; c++) begin
        tap_r[c] <= TAP_DEF;
        rot_r[c] <= '0;
      end
    end else begin
      tap_ld_r <= '0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            done_r  <= 1'b0;
            ch_ok_r <= '0;
            ch      <= '0;
            tap     <= '0;
          end
        end
        ST_LOAD: begin
          tap_r[ch]    <= tap;
          tap_ld_r[ch] <= 1'b1;
        end
        ST_SAMPLE: begin
          if (cnt == '0) begin
            first_w <= din_ch;
            mism    <= 1'b0;
          end else if (din_ch != first_w) begin
            mism <= 1'b1;
          end
        end
        ST_EVAL: begin
          if (tap != TAP_LAST) tap <= tap + {{(TAPW-1){1'b0}}, 1'b1};
        end
        ST_CLOAD: begin
          tap_ld_r[ch] <= 1'b1;
          if (eye_pass) begin
            tap_r[ch] <= centre;
            ch_fail   <= 1'b0;
          end else begin
            tap_r[ch] <= TAP_DEF;
            ch_fail   <= 1'b1;
          end
        end
        ST_ROT: begin
          if (!ch_fail && hit) begin
            rot_r[ch]   <= hit_r;
            ch_ok_r[ch] <= 1'b1;
          end else begin
            rot_r[ch] <= '0;
          end
        end
        ST_NEXT_CH: begin
          if (ch != CH_LAST) begin
            ch  <= ch + {{(CHW-1){1'b0}}, 1'b1};
            tap <= '0;
          end else begin
            done_r <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state != ST_IDLE);
  assign bus.done   = done_r;
  assign bus.ch_ok  = ch_ok_r;
  assign bus.tap_ld = tap_ld_r;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [NBITS-1:0] dout_p1;

    assign din_w[c]                     = bus.din[c*NBITS +: NBITS];
    assign bus.tap_val[c*TAPW +: TAPW]  = tap_r[c];

    // p0 -> p1: rotation-corrected word register
    always_ff @(posedge frame_clk or negedge rst_n) begin
      if (!rst_n) dout_p1 <= '0;
      else        dout_p1 <= NBITS'(rotl(MAXW'(din_w[c]), 32'(rot_r[c]), NBITS));
    end

    assign bus.dout[c*NBITS +: NBITS] = dout_p1;
  end

endmodule
